// File: rtl/autoneg_ctrl_pkg.sv
// Shared encodings for the 1000BASE-X auto-negotiation controller:
// xmit codes, Config_Reg bit positions and the arbitration state type.
package pcs_an_pkg;

  localparam logic [1:0] XMIT_CONFIG = 2'd0;
  localparam logic [1:0] XMIT_IDLE   = 2'd1;
  localparam logic [1:0] XMIT_DATA   = 2'd2;

  localparam int CFG_ACK_BIT = 14;
  localparam int CFG_FD_BIT  = 5;
  localparam int CFG_HD_BIT  = 6;

  localparam logic [15:0] CFG_ACK_MASK = 16'h0001 << CFG_ACK_BIT;

  typedef enum logic [2:0] {
    AN_ENABLE            = 3'd0,
    AN_RESTART           = 3'd1,
    ABILITY_DETECT       = 3'd2,
    ACKNOWLEDGE_DETECT   = 3'd3,
    COMPLETE_ACKNOWLEDGE = 3'd4,
    IDLE_DETECT          = 3'd5,
    LINK_OK              = 3'd6,
    AN_DISABLE_LINK_OK   = 3'd7
  } an_state_t;

  // Config_Reg with the acknowledge bit removed, used for every ability comparison.
  function automatic logic [15:0] mask_ack(input logic [15:0] v);
    return v & ~CFG_ACK_MASK;
  endfunction

endpackage

// File: rtl/autoneg_ctrl_if.sv
// PCS-side signals of the auto-negotiation controller: receive indications in,
// transmit sequencing out.
interface autoneg_ctrl_if;

  logic        sync_status;
  logic        rx_cfg_valid;
  logic [15:0] rx_Config_Reg;
  logic        rx_idle;
  logic [1:0]  xmit;
  logic        xmit_data;
  logic [15:0] tx_Config_Reg;

  modport master (
    input  sync_status, rx_cfg_valid, rx_Config_Reg, rx_idle,
    output xmit, xmit_data, tx_Config_Reg
  );

  modport slave (
    output sync_status, rx_cfg_valid, rx_Config_Reg, rx_idle,
    input  xmit, xmit_data, tx_Config_Reg
  );

endinterface

// File: rtl/autoneg_ctrl_an_match_detect.sv
// Consistency counters over received /C/ and /I/ sets; produces the match
// qualifiers the arbitration FSM branches on.
module an_match_detect
  import pcs_an_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cfg_valid,
  input  logic [15:0] cfg,
  input  logic        idle,
  input  logic [15:0] lp_ability,
  output logic        ability_match,
  output logic        acknowledge_match,
  output logic        zero_match,
  output logic        idle_match,
  output logic        cfg_mismatch,
  output logic        abl_full,
  output logic [15:0] cfg_stored
);

  logic [15:0] cfg_reg;
  logic [1:0]  abl_cnt_reg;
  logic [1:0]  ack_cnt_reg;
  logic [1:0]  idle_cnt_reg;
  logic [15:0] cmp;
  logic        same;

  assign cmp  = mask_ack(cfg);
  assign same = (cmp == cfg_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg      <= '0;
      abl_cnt_reg  <= '0;
      ack_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
    end else if (clr) begin
      cfg_reg      <= '0;
      abl_cnt_reg  <= '0;
      ack_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
    end else if (cfg_valid) begin
      idle_cnt_reg <= '0;
      if (same) begin
        if (abl_cnt_reg != 2'd3) abl_cnt_reg <= abl_cnt_reg + 2'd1;
      end else begin
        cfg_reg     <= cmp;
        abl_cnt_reg <= 2'd1;
      end
      // Acknowledge counting restarts whenever a frame arrives without the ack bit.
      if (!cfg[CFG_ACK_BIT]) begin
        ack_cnt_reg <= '0;
      end else if (same) begin
        if (ack_cnt_reg != 2'd3) ack_cnt_reg <= ack_cnt_reg + 2'd1;
      end else begin
        ack_cnt_reg <= 2'd1;
      end
    end else if (idle && idle_cnt_reg != 2'd3) begin
      idle_cnt_reg <= idle_cnt_reg + 2'd1;
    end
  end

  assign abl_full          = (abl_cnt_reg == 2'd3);
  assign ability_match     = abl_full && (cfg_reg != '0);
  assign zero_match        = abl_full && (cfg_reg == '0);
  assign acknowledge_match = (ack_cnt_reg == 2'd3);
  assign idle_match        = (idle_cnt_reg == 2'd3);
  assign cfg_mismatch      = cfg_valid && (cmp != mask_ack(lp_ability));
  assign cfg_stored        = cfg_reg;

endmodule

// File: rtl/autoneg_ctrl.sv
// Clause 37 style auto-negotiation arbitration: sequences xmit and the
// transmitted Config_Reg, and reports the partner's ability once the link is up.
module autoneg_ctrl
  import pcs_an_pkg::*;
#(
  parameter int LINK_TIMER = 16,
  parameter int TMR_W      = 21
) (
  input  logic                  GTX_CLK,
  input  logic                  mr_main_reset,
  input  logic                  mr_an_enable,
  input  logic                  mr_restart_an,
  input  logic [15:0]           mr_adv_ability,
  autoneg_ctrl_if.master        pcs,
  output logic [15:0]           mr_lp_adv_ability,
  output logic                  mr_an_complete
);

  an_state_t   state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [1:0]  xmit_reg, xmit_next;
  logic        xmit_data_reg, xmit_data_next;
  logic [15:0] tx_cfg_reg, tx_cfg_next;
  logic [15:0] lp_reg, lp_next;
  logic        complete_reg, complete_next;
  logic        clr;
  logic        link_timer_done;

  logic ability_match, acknowledge_match, zero_match, idle_match;
  logic cfg_mismatch, abl_full;
  logic [15:0] cfg_stored;

  an_match_detect u_match (
    .clk               (GTX_CLK),
    .rst_n             (mr_main_reset),
    .clr               (clr),
    .cfg_valid         (pcs.rx_cfg_valid),
    .cfg               (pcs.rx_Config_Reg),
    .idle              (pcs.rx_idle),
    .lp_ability        (lp_reg),
    .ability_match     (ability_match),
    .acknowledge_match (acknowledge_match),
    .zero_match        (zero_match),
    .idle_match        (idle_match),
    .cfg_mismatch      (cfg_mismatch),
    .abl_full          (abl_full),
    .cfg_stored        (cfg_stored)
  );

  assign link_timer_done = (timer_reg == TMR_W'(LINK_TIMER - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      AN_ENABLE:            state_next = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
      AN_RESTART:           if (link_timer_done) state_next = ABILITY_DETECT;
      ABILITY_DETECT: begin
        if (ability_match)   state_next = ACKNOWLEDGE_DETECT;
        else if (zero_match) state_next = AN_ENABLE;
      end
      ACKNOWLEDGE_DETECT: begin
        if (cfg_mismatch) state_next = AN_ENABLE;
        else if (acknowledge_match && cfg_stored == mask_ack(lp_reg))
          state_next = COMPLETE_ACKNOWLEDGE;
      end
      COMPLETE_ACKNOWLEDGE: begin
        if (cfg_mismatch) state_next = AN_ENABLE;
        else if (link_timer_done && ability_match) state_next = IDLE_DETECT;
      end
      IDLE_DETECT: begin
        if (ability_match) state_next = AN_ENABLE;
        else if (link_timer_done && idle_match) state_next = LINK_OK;
      end
      LINK_OK:              if (pcs.rx_cfg_valid && abl_full) state_next = AN_ENABLE;
      AN_DISABLE_LINK_OK:   if (mr_an_enable) state_next = AN_ENABLE;
      default:              state_next = AN_ENABLE;
    endcase
    if (mr_an_enable && (!pcs.sync_status || mr_restart_an)) state_next = AN_ENABLE;

    // Counters are cleared in AN_ENABLE and on entry to IDLE_DETECT, so a fresh
    // ability_match there means the partner really restarted.
    clr = (state_reg == AN_ENABLE) ||
          (state_next == IDLE_DETECT && state_reg != IDLE_DETECT);

    timer_next = (state_next != state_reg) ? '0 :
                 (timer_reg != '1) ? timer_reg + 1'b1 : timer_reg;

    xmit_next     = XMIT_CONFIG;
    tx_cfg_next   = '0;
    complete_next = 1'b0;
    lp_next       = lp_reg;
    case (state_next)
      ABILITY_DETECT:       tx_cfg_next = mask_ack(mr_adv_ability);
      ACKNOWLEDGE_DETECT,
      COMPLETE_ACKNOWLEDGE: tx_cfg_next = mr_adv_ability | CFG_ACK_MASK;
      IDLE_DETECT: begin
        xmit_next   = XMIT_IDLE;
        tx_cfg_next = mr_adv_ability | CFG_ACK_MASK;
      end
      LINK_OK: begin
        xmit_next     = XMIT_DATA;
        tx_cfg_next   = mr_adv_ability | CFG_ACK_MASK;
        complete_next = 1'b1;
      end
      AN_DISABLE_LINK_OK:   xmit_next = XMIT_DATA;
      default:              xmit_next = XMIT_CONFIG;
    endcase
    xmit_data_next = (xmit_next == XMIT_DATA);
    if (state_reg == ABILITY_DETECT && state_next == ACKNOWLEDGE_DETECT)
      lp_next = cfg_stored;
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_reg     <= AN_ENABLE;
      timer_reg     <= '0;
      xmit_reg      <= XMIT_CONFIG;
      xmit_data_reg <= 1'b0;
      tx_cfg_reg    <= '0;
      lp_reg        <= '0;
      complete_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      xmit_reg      <= xmit_next;
      xmit_data_reg <= xmit_data_next;
      tx_cfg_reg    <= tx_cfg_next;
      lp_reg        <= lp_next;
      complete_reg  <= complete_next;
    end
  end

  assign pcs.xmit          = xmit_reg;
  assign pcs.xmit_data     = xmit_data_reg;
  assign pcs.tx_Config_Reg = tx_cfg_reg;
  assign mr_lp_adv_ability = lp_reg;
  assign mr_an_complete    = complete_reg;

endmodule

// File: tb/tb_autoneg_ctrl.sv
// Directed bench for autoneg_ctrl: negotiation, restarts, mismatch exits,
// forced DATA mode and asynchronous reset.
module tb_autoneg_ctrl;

  logic        GTX_CLK = 1'b0;
  logic        mr_main_reset;
  logic        mr_an_enable;
  logic        mr_restart_an;
  logic [15:0] mr_adv_ability;
  logic [15:0] mr_lp_adv_ability;
  logic        mr_an_complete;

  int checks = 0;
  int errors = 0;

  autoneg_ctrl_if pcs ();

  autoneg_ctrl #(.LINK_TIMER(16), .TMR_W(21)) dut (
    .GTX_CLK           (GTX_CLK),
    .mr_main_reset     (mr_main_reset),
    .mr_an_enable      (mr_an_enable),
    .mr_restart_an     (mr_restart_an),
    .mr_adv_ability    (mr_adv_ability),
    .pcs               (pcs),
    .mr_lp_adv_ability (mr_lp_adv_ability),
    .mr_an_complete    (mr_an_complete)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  task automatic tick();
    @(posedge GTX_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [15:0] v);
    pcs.rx_cfg_valid  = 1'b1;
    pcs.rx_Config_Reg = v;
    tick();
    pcs.rx_cfg_valid  = 1'b0;
  endtask

  task automatic send_frames(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send_cfg(v);
      tick();
    end
  endtask

  task automatic wait_tx(input logic [15:0] v, input string tag);
    int n = 0;
    while (pcs.tx_Config_Reg !== v && n < 200) begin
      tick();
      n++;
    end
    chk(tag, pcs.tx_Config_Reg, v);
  endtask

  task automatic wait_xmit(input logic [1:0] v, input string tag);
    int n = 0;
    while (pcs.xmit !== v && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {14'd0, pcs.xmit}, {14'd0, v});
  endtask

  initial begin
    mr_main_reset     = 1'b0;
    mr_an_enable      = 1'b1;
    mr_restart_an     = 1'b0;
    mr_adv_ability    = 16'h0020;
    pcs.sync_status   = 1'b1;
    pcs.rx_cfg_valid  = 1'b0;
    pcs.rx_Config_Reg = 16'h0000;
    pcs.rx_idle       = 1'b0;
    repeat (3) tick();

    chk("rst_xmit", {14'd0, pcs.xmit}, 16'd0);
    chk("rst_xmit_data", {15'd0, pcs.xmit_data}, 16'd0);
    chk("rst_tx_cfg", pcs.tx_Config_Reg, 16'h0000);
    chk("rst_lp", mr_lp_adv_ability, 16'h0000);
    chk("rst_complete", {15'd0, mr_an_complete}, 16'd0);

    // AN_ENABLE then 16 cycles of AN_RESTART with a zero Config_Reg
    mr_main_reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("restart_tx_zero", pcs.tx_Config_Reg, 16'h0000);
    end
    tick();
    chk("ability_tx", pcs.tx_Config_Reg, 16'h0020);
    chk("ability_xmit", {14'd0, pcs.xmit}, 16'd0);

    send_frames(16'h0020, 3);
    chk("ack_tx", pcs.tx_Config_Reg, 16'h4020);
    chk("ack_lp", mr_lp_adv_ability, 16'h0020);

    send_frames(16'h4020, 3);
    chk("cack_xmit", {14'd0, pcs.xmit}, 16'd0);
    chk("cack_tx", pcs.tx_Config_Reg, 16'h4020);
    pcs.rx_idle = 1'b1;
    repeat (15) tick();
    chk("cack_timer_hold", {14'd0, pcs.xmit}, 16'd0);
    tick();
    chk("idle_xmit", {14'd0, pcs.xmit}, 16'd1);
    chk("idle_xmit_data", {15'd0, pcs.xmit_data}, 16'd0);
    chk("idle_complete", {15'd0, mr_an_complete}, 16'd0);
    repeat (15) tick();
    chk("idle_timer_hold", {14'd0, pcs.xmit}, 16'd1);
    tick();
    chk("linkok_xmit", {14'd0, pcs.xmit}, 16'd2);
    chk("linkok_xmit_data", {15'd0, pcs.xmit_data}, 16'd1);
    chk("linkok_complete", {15'd0, mr_an_complete}, 16'd1);
    chk("linkok_lp", mr_lp_adv_ability, 16'h0020);

    // Loss of sync for one cycle forces AN_ENABLE on the next edge
    pcs.sync_status = 1'b0;
    tick();
    pcs.sync_status = 1'b1;
    chk("sync_drop_xmit", {14'd0, pcs.xmit}, 16'd0);
    chk("sync_drop_complete", {15'd0, mr_an_complete}, 16'd0);

    pcs.rx_idle = 1'b0;
    wait_tx(16'h0020, "reneg_ability_tx");
    send_frames(16'h0020, 3);
    send_frames(16'h4020, 3);
    pcs.rx_idle = 1'b1;
    wait_xmit(2'd2, "reneg_linkok_xmit");
    chk("reneg_complete", {15'd0, mr_an_complete}, 16'd1);

    // Partner restarts from LINK_OK: the fourth consistent /C/ drops the link
    pcs.rx_idle = 1'b0;
    send_frames(16'h0020, 3);
    chk("linkok_3cfg_hold", {14'd0, pcs.xmit}, 16'd2);
    send_cfg(16'h0020);
    chk("linkok_partner_restart", {14'd0, pcs.xmit}, 16'd0);

    // Mismatching ability in ACKNOWLEDGE_DETECT
    wait_tx(16'h0020, "mm_ability_tx");
    send_frames(16'h0020, 3);
    chk("mm_ack_tx", pcs.tx_Config_Reg, 16'h4020);
    send_cfg(16'h4040);
    chk("mm_tx_zero", pcs.tx_Config_Reg, 16'h0000);
    chk("mm_xmit", {14'd0, pcs.xmit}, 16'd0);

    // All-zero partner Config_Reg in ABILITY_DETECT
    wait_tx(16'h0020, "zero_ability_tx");
    send_frames(16'h0000, 3);
    chk("zero_match_tx", pcs.tx_Config_Reg, 16'h0000);

    // Asynchronous reset in COMPLETE_ACKNOWLEDGE
    wait_tx(16'h0020, "areset_ability_tx");
    send_frames(16'h0020, 3);
    send_frames(16'h4020, 3);
    repeat (4) tick();
    chk("areset_pre_tx", pcs.tx_Config_Reg, 16'h4020);
    chk("areset_pre_lp", mr_lp_adv_ability, 16'h0020);
    #3;
    mr_main_reset = 1'b0;
    #1;
    chk("areset_tx", pcs.tx_Config_Reg, 16'h0000);
    chk("areset_lp", mr_lp_adv_ability, 16'h0000);
    chk("areset_xmit", {14'd0, pcs.xmit}, 16'd0);
    chk("areset_xmit_data", {15'd0, pcs.xmit_data}, 16'd0);
    chk("areset_complete", {15'd0, mr_an_complete}, 16'd0);

    // Auto-negotiation disabled: DATA forced, then re-enabled
    tick();
    mr_an_enable  = 1'b0;
    mr_main_reset = 1'b1;
    tick();
    tick();
    chk("dis_xmit", {14'd0, pcs.xmit}, 16'd2);
    chk("dis_xmit_data", {15'd0, pcs.xmit_data}, 16'd1);
    chk("dis_complete", {15'd0, mr_an_complete}, 16'd0);
    mr_an_enable = 1'b1;
    tick();
    chk("reen_xmit", {14'd0, pcs.xmit}, 16'd0);
    chk("reen_xmit_data", {15'd0, pcs.xmit_data}, 16'd0);
    wait_tx(16'h0020, "reen_ability_tx");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/autoneg_ctrl.md
Name: autoneg_ctrl

Overview:
- Simplified IEEE 802.3 Clause 37 auto-negotiation controller for the 1000BASE-X PCS.
- Sequences the transmit path by driving `xmit` (CONFIGURATION / IDLE / DATA) and supplies the 16-bit `tx_Config_Reg` carried in /C/ ordered sets.
- Consumes decoded /C/ and /I/ indications from receive, plus `sync_status` from Synchronization.
- Sits beside transmit/receive and replaces the constant `xmit` driven by the tester.

Parameters:
- LINK_TIMER, 16, link_timer terminal count in GTX_CLK cycles (1_250_000 for silicon at 125 MHz).
- TMR_W, 21, width of the link_timer counter; must satisfy 2^TMR_W > LINK_TIMER.

Ports:
- GTX_CLK  in  1  clock, all logic on posedge.
- mr_main_reset  in  1  asynchronous active-low reset.
- mr_an_enable  in  1  1 = run auto-negotiation, 0 = force DATA.
- mr_restart_an  in  1  level; restart negotiation while high.
- mr_adv_ability  in  16  local advertised Config_Reg; bit 14 ignored.
- sync_status  in  1  1 = code-group sync acquired.
- rx_cfg_valid  in  1  one-cycle strobe: a /C/ set was decoded.
- rx_Config_Reg  in  16  Config_Reg value, valid with `rx_cfg_valid`.
- rx_idle  in  1  one-cycle strobe: an /I/ set was decoded.
- xmit  out  2  0 = CONFIGURATION, 1 = IDLE, 2 = DATA.
- xmit_data  out  1  1 iff xmit == DATA (legacy 1-bit consumers).
- tx_Config_Reg  out  16  value transmit places in /C/ sets.
- mr_lp_adv_ability  out  16  latched link-partner ability.
- mr_an_complete  out  1  1 in LINK_OK.

Behaviour:
- Reset (mr_main_reset = 0, asynchronous):
  - state = AN_ENABLE, xmit = 0, xmit_data = 0, tx_Config_Reg = 0, mr_lp_adv_ability = 0, mr_an_complete = 0, timer = 0, match counters = 0.
- All outputs are registered; each output takes its new state's value on the clock edge that enters the state.
- Match logic (updated only on `rx_cfg_valid`):
  - cmp = rx_Config_Reg with bit 14 masked.
  - If cmp equals the stored value, abl_cnt saturates upward at 3; otherwise store cmp and set abl_cnt = 1.
  - ability_match = abl_cnt == 3 and stored value != 0.
  - ack_cnt follows the same rule but additionally requires bit 14 = 1; a frame with bit 14 = 0 clears ack_cnt to 0.
  - acknowledge_match = ack_cnt == 3.
  - zero_match = abl_cnt == 3 and stored value == 0.
  - idle_cnt increments on `rx_idle` (saturates at 3) and clears on `rx_cfg_valid`.
- Link timer: loaded to 0 on entry to a timed state, increments each cycle, saturates.
  - link_timer_done = 1 when timer == LINK_TIMER - 1, so done asserts exactly LINK_TIMER cycles after entry.
- Global override, evaluated before any transition:
  - if mr_an_enable = 1 and (sync_status = 0 or mr_restart_an = 1): next = AN_ENABLE.
- States, with outputs and transitions:
  - AN_ENABLE: xmit = CONFIG, tx_Config_Reg = 0, clear all match counters.
    - mr_an_enable = 0 → AN_DISABLE_LINK_OK; otherwise → AN_RESTART.
  - AN_RESTART: xmit = CONFIG, tx_Config_Reg = 0, timer running.
    - link_timer_done → ABILITY_DETECT.
  - ABILITY_DETECT: tx_Config_Reg = mr_adv_ability with bit 14 = 0.
    - ability_match → ACKNOWLEDGE_DETECT; latch mr_lp_adv_ability = rx_Config_Reg.
    - zero_match → AN_ENABLE.
  - ACKNOWLEDGE_DETECT: tx_Config_Reg bit 14 = 1.
    - acknowledge_match with cmp == latched ability → COMPLETE_ACKNOWLEDGE.
    - Any `rx_cfg_valid` whose cmp differs from the latched ability (bit 14 masked) → AN_ENABLE.
  - COMPLETE_ACKNOWLEDGE: bit 14 = 1, timer running.
    - link_timer_done and ability_match → IDLE_DETECT.
    - Mismatching cfg, same rule as ACKNOWLEDGE_DETECT → AN_ENABLE.
  - IDLE_DETECT: xmit = IDLE, timer running.
    - link_timer_done and idle_cnt == 3 → LINK_OK.
    - ability_match (partner restarted) → AN_ENABLE.
  - LINK_OK: xmit = DATA, mr_an_complete = 1.
    - abl_cnt == 3 on any cfg (partner sending /C/) → AN_ENABLE.
  - AN_DISABLE_LINK_OK: xmit = DATA, mr_an_complete = 0.
    - mr_an_enable rising to 1 → AN_ENABLE.
- Simultaneous events:
  - The global override beats every local transition.
  - In IDLE_DETECT, timer done plus ability_match → AN_ENABLE.
- Unused state encodings → AN_ENABLE.

Decomposition:
- Package `pcs_an_pkg`:
  - XMIT_CONFIG / XMIT_IDLE / XMIT_DATA encodings.
  - AN state localparams.
  - CFG_ACK_BIT = 14, CFG_FD_BIT = 5, CFG_HD_BIT = 6.
- Sub-module `an_match_detect`:
  - abl/ack/idle counters and stored cfg.
  - Outputs ability_match, acknowledge_match, zero_match, idle_match, cfg_mismatch.
  - Counters are cleared by a `clr` input from the FSM.

Test Plan:
- Reset released, mr_an_enable = 1, sync_status = 1, adv = 16'h0020 → xmit = 0, tx_Config_Reg = 0 for 16 cycles, then tx_Config_Reg = 16'h0020.
- Partner sends 3× 16'h0020, then 3× 16'h4020, then idles; keep /I/ strobes running → tx_Config_Reg = 16'h4020, then xmit = 1 after the timer, then xmit = 2, mr_an_complete = 1, mr_lp_adv_ability = 16'h0020.
- In ACKNOWLEDGE_DETECT the partner sends 16'h4040 → AN_ENABLE next cycle, tx_Config_Reg = 0.
- In LINK_OK, drop sync_status for 1 cycle → xmit = 0 and mr_an_complete = 0 on the next edge; renegotiation completes again.
- mr_an_enable = 0 after reset → xmit = 2, xmit_data = 1 within 2 cycles; raising mr_an_enable restarts AN.
- Assert mr_main_reset = 0 mid-COMPLETE_ACKNOWLEDGE, asynchronously between edges → all outputs are 0 immediately.
